frv_dmem_arbiter: RTL and testbench
===================================

Name: frv_dmem_arbiter

Overview:
Shares the single core data-memory port between two requesters. Requester 0 is the memory-stage load/store unit. Requester 1 is a secondary master, such as the debug module or a co-processor. The block arbitrates the request channel (req/gnt), tracks up to MAX_OUTSTANDING accepted transactions in an ID FIFO, and routes each in-order response (recv/ack) back to the requester that issued it.

Parameters:
XLEN, 32, data/address width.
MAX_OUTSTANDING, 2, depth of the outstanding-ID FIFO; legal values 1..4.

Ports:
g_clk  input  1  global clock
g_reset  input  1  asynchronous, active-high reset
rq_req  input  2  per-requester request valid; bit n = requester n
rq_wen  input  2  per-requester write enable
rq_strb  input  8  byte strobes; [4n+3:4n] = requester n
rq_wdata  input  2*XLEN  write data; [XLEN*n+XL:XLEN*n] = requester n
rq_addr  input  2*XLEN  address; same packing as rq_wdata
rq_gnt  output  2  request accepted, one-hot or zero
rq_recv  output  2  response valid to requester n, one-hot or zero
rq_ack  input  2  requester n accepts response
rsp_rdata  output  XLEN  response data, broadcast to both requesters
rsp_error  output  1  response error, broadcast to both requesters
dmem_req  output  1  memory request
dmem_wen  output  1  memory write enable
dmem_strb  output  4  memory byte strobes
dmem_wdata  output  XLEN  memory write data
dmem_addr  output  XLEN  memory address
dmem_gnt  input  1  memory accepted request
dmem_recv  input  1  memory response valid
dmem_ack  output  1  response accepted
dmem_rdata  input  XLEN  memory read data
dmem_error  input  1  memory response error
arb_busy  output  1  FIFO non-empty or dmem_req high
spurious  output  1  one-cycle pulse: dmem_recv while FIFO empty

Behaviour:
- Reset (asynchronous): FIFO empty, round-robin pointer set to prefer requester 0, lock cleared, spurious=0. While the FIFO is empty, all outputs are 0 except dmem_ack: it is 1 when dmem_recv=1, to sink stray responses.
- Selection is combinational:
  - Only one requester asserting rq_req: that requester is selected.
  - Both asserting: the pointer's preferred requester is selected.
- dmem_req = selected rq_req && !fifo_full. dmem_wen/strb/wdata/addr are muxed from the selected requester; they are 0 when no requester is selected.
- Lock: if dmem_req=1 and dmem_gnt=0, the lock register holds the selected index. The next cycle must re-select the same requester even if the other requester has priority. Requesters hold their request signals stable until granted. The lock clears on the grant.
- rq_gnt[sel] = dmem_gnt && dmem_req. Zero-latency grant passthrough.
- On a grant: push sel into the FIFO, and set the pointer to prefer the other requester (round-robin).
- fifo_full (count == MAX_OUTSTANDING) forces dmem_req=0 and rq_gnt=0. A pop in the same cycle does not unblock; the new request proceeds the next cycle.
- Response routing uses the FIFO head index h:
  - rq_recv[h] = dmem_recv && !fifo_empty.
  - dmem_ack = rq_ack[h] when the FIFO is non-empty.
  - rsp_rdata and rsp_error are passed through combinationally.
  - Pop when dmem_recv && dmem_ack.
- Simultaneous push and pop (not full): count is unchanged; the new ID is written behind the head.
- Spurious response (dmem_recv with FIFO empty): dmem_ack=1, rq_recv=0, spurious pulses high for that cycle.
- rq_ack on a requester that is not the head is ignored.
- Count width is clog2(MAX_OUTSTANDING)+1. Read and write pointers wrap modulo MAX_OUTSTANDING.
- Reset asserted mid-transaction discards outstanding IDs. Subsequent responses are treated as spurious.

Test Plan:
- Solo traffic: rq_req=01, addr 0x100, dmem_gnt=1 the same cycle → rq_gnt=01, dmem_addr=0x100. dmem_recv 2 cycles later with rdata 0xDEADBEEF → rq_recv=01, rsp_rdata=0xDEADBEEF. Ack pops; arb_busy drops.
- Contention: rq_req=11 held for 4 grants, dmem_gnt=1 every cycle, responses returned promptly → grant order 0,1,0,1.
- Lock: rq_req=10, dmem_gnt=0 for 3 cycles, then rq_req=11 → requester 1 stays selected until dmem_gnt; rq_gnt=10, then requester 0 is served next.
- Full FIFO (MAX_OUTSTANDING=2): 2 grants with no responses → dmem_req=0 despite rq_req=01. Respond and ack once → dmem_req=1 the following cycle, not the same cycle.
- Ordering: grant requester 0 then requester 1; two responses with error=1 then error=0 → rq_recv=01 with rsp_error=1, then rq_recv=10 with rsp_error=0. A requester-0 response stalled (rq_ack=0) holds dmem_ack=0.
- Spurious and reset: dmem_recv=1 with FIFO empty → dmem_ack=1, spurious=1, rq_recv=00. Assert g_reset with 1 outstanding → all state clears immediately; the next dmem_recv is spurious.

Source files
------------

// File: rtl/frv_dmem_arbiter.sv
// Two-requester arbiter for the core data-memory port.
// Ports: rq_* requester side, dmem_* memory side, arb_busy/spurious status.
module frv_dmem_arbiter #(
  parameter int XLEN            = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic              g_clk,
  input  logic              g_reset,
  input  logic [1:0]        rq_req,
  input  logic [1:0]        rq_wen,
  input  logic [7:0]        rq_strb,
  input  logic [2*XLEN-1:0] rq_wdata,
  input  logic [2*XLEN-1:0] rq_addr,
  output logic [1:0]        rq_gnt,
  output logic [1:0]        rq_recv,
  input  logic [1:0]        rq_ack,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_error,
  output logic              dmem_req,
  output logic              dmem_wen,
  output logic [3:0]        dmem_strb,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [XLEN-1:0]   dmem_addr,
  input  logic              dmem_gnt,
  input  logic              dmem_recv,
  output logic              dmem_ack,
  input  logic [XLEN-1:0]   dmem_rdata,
  input  logic              dmem_error,
  output logic              arb_busy,
  output logic              spurious
);

  localparam int PW =
    (MAX_OUTSTANDING > 1) ?
    $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW =
    $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CW-1:0] FULL_CNT =
    CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LAST_PTR =
    PW'(MAX_OUTSTANDING - 1);

  logic                       rr_ptr;
  logic                       lock_vld;
  logic                       lock_idx;
  logic [MAX_OUTSTANDING-1:0] id_q;
  logic [PW-1:0]              wr_ptr;
  logic [PW-1:0]              rd_ptr;
  logic [CW-1:0]              count;

  logic sel;
  logic sel_vld;
  logic fifo_full;
  logic fifo_empty;
  logic head;
  logic push;
  logic pop;

  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  assign head       = id_q[rd_ptr];

  // A stalled request keeps its requester
  // selected so its payload cannot change
  // under the memory before the grant.
  always_comb begin
    sel     = 1'b0;
    sel_vld = 1'b0;
    unique case (1'b1)
      lock_vld: begin
        sel     = lock_idx;
        sel_vld = rq_req[lock_idx];
      end
      (!lock_vld && rq_req == 2'b11): begin
        sel     = rr_ptr;
        sel_vld = 1'b1;
      end
      (!lock_vld && rq_req == 2'b10): begin
        sel     = 1'b1;
        sel_vld = 1'b1;
      end
      (!lock_vld && rq_req == 2'b01): begin
        sel     = 1'b0;
        sel_vld = 1'b1;
      end
      default: begin
        sel     = 1'b0;
        sel_vld = 1'b0;
      end
    endcase
  end

  assign dmem_req = sel_vld && !fifo_full;
  assign push     = dmem_req && dmem_gnt;

  assign rq_gnt =
    !push ? 2'b00 :
    sel   ? 2'b10 : 2'b01;

  assign dmem_wen =
    sel_vld & (sel ? rq_wen[1] : rq_wen[0]);
  assign dmem_strb =
    {4{sel_vld}} &
    (sel ? rq_strb[7:4] : rq_strb[3:0]);
  assign dmem_wdata =
    {XLEN{sel_vld}} &
    (sel ? rq_wdata[2*XLEN-1:XLEN]
         : rq_wdata[XLEN-1:0]);
  assign dmem_addr =
    {XLEN{sel_vld}} &
    (sel ? rq_addr[2*XLEN-1:XLEN]
         : rq_addr[XLEN-1:0]);

  // With nothing outstanding, any response
  // is stray: sink it so memory never hangs.
  assign dmem_ack =
    fifo_empty ? dmem_recv : rq_ack[head];
  assign pop =
    dmem_recv && dmem_ack && !fifo_empty;
  assign spurious = dmem_recv && fifo_empty;

  assign rq_recv =
    (!dmem_recv || fifo_empty) ? 2'b00 :
    head ? 2'b10 : 2'b01;
  assign rsp_rdata =
    {XLEN{!fifo_empty}} & dmem_rdata;
  assign rsp_error =
    !fifo_empty && dmem_error;

  assign arb_busy = !fifo_empty || dmem_req;

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      rr_ptr   <= 1'b0;
      lock_vld <= 1'b0;
      lock_idx <= 1'b0;
    end else begin
      lock_vld <= dmem_req && !dmem_gnt;
      if (dmem_req && !dmem_gnt)
        lock_idx <= sel;
      if (push)
        rr_ptr <= ~sel;
    end
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      id_q   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        id_q[wr_ptr] <= sel;
        wr_ptr <= (wr_ptr == LAST_PTR) ?
          '0 : wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= (rd_ptr == LAST_PTR) ?
          '0 : rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_frv_dmem_arbiter.sv
// Directed testbench for frv_dmem_arbiter.
// Drives vectors after each rising edge.
module tb_frv_dmem_arbiter;

  localparam int XLEN = 32;

  logic              g_clk = 1'b0;
  logic              g_reset;
  logic [1:0]        rq_req;
  logic [1:0]        rq_wen;
  logic [7:0]        rq_strb;
  logic [2*XLEN-1:0] rq_wdata;
  logic [2*XLEN-1:0] rq_addr;
  logic [1:0]        rq_gnt;
  logic [1:0]        rq_recv;
  logic [1:0]        rq_ack;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_error;
  logic              dmem_req;
  logic              dmem_wen;
  logic [3:0]        dmem_strb;
  logic [XLEN-1:0]   dmem_wdata;
  logic [XLEN-1:0]   dmem_addr;
  logic              dmem_gnt;
  logic              dmem_recv;
  logic              dmem_ack;
  logic [XLEN-1:0]   dmem_rdata;
  logic              dmem_error;
  logic              arb_busy;
  logic              spurious;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 g_clk = ~g_clk;

  frv_dmem_arbiter #(
    .XLEN(XLEN),
    .MAX_OUTSTANDING(2)
  ) dut (
    .g_clk(g_clk),
    .g_reset(g_reset),
    .rq_req(rq_req),
    .rq_wen(rq_wen),
    .rq_strb(rq_strb),
    .rq_wdata(rq_wdata),
    .rq_addr(rq_addr),
    .rq_gnt(rq_gnt),
    .rq_recv(rq_recv),
    .rq_ack(rq_ack),
    .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error),
    .dmem_req(dmem_req),
    .dmem_wen(dmem_wen),
    .dmem_strb(dmem_strb),
    .dmem_wdata(dmem_wdata),
    .dmem_addr(dmem_addr),
    .dmem_gnt(dmem_gnt),
    .dmem_recv(dmem_recv),
    .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata),
    .dmem_error(dmem_error),
    .arb_busy(arb_busy),
    .spurious(spurious)
  );

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
  endtask

  task automatic tick;
    @(posedge g_clk);
    #1;
  endtask

  task automatic idle;
    rq_req    = 2'b00;
    rq_ack    = 2'b00;
    dmem_gnt  = 1'b0;
    dmem_recv = 1'b0;
    dmem_error = 1'b0;
    dmem_rdata = '0;
  endtask

  task automatic pulse_reset;
    g_reset = 1'b1;
    tick();
    g_reset = 1'b0;
  endtask

  initial begin
    g_reset  = 1'b1;
    rq_wen   = 2'b00;
    rq_strb  = 8'h00;
    rq_wdata = '0;
    rq_addr  = '0;
    idle();
    tick();
    tick();
    #1;
    check("rst_gnt", 64'(rq_gnt), 64'd0);
    check("rst_req", 64'(dmem_req), 64'd0);
    check("rst_busy", 64'(arb_busy), 64'd0);
    check("rst_spur", 64'(spurious), 64'd0);
    check("rst_ack", 64'(dmem_ack), 64'd0);
    g_reset = 1'b0;
    tick();

    // Solo traffic from requester 0
    rq_req   = 2'b01;
    rq_wen   = 2'b01;
    rq_strb  = 8'h3F;
    rq_wdata = {32'h2222_2222, 32'h1111_1111};
    rq_addr  = {32'h0000_0200, 32'h0000_0100};
    dmem_gnt = 1'b1;
    #1;
    check("solo_gnt", 64'(rq_gnt), 64'h1);
    check("solo_addr", 64'(dmem_addr), 64'h100);
    check("solo_wen", 64'(dmem_wen), 64'h1);
    check("solo_strb", 64'(dmem_strb), 64'hF);
    check("solo_wdat", 64'(dmem_wdata),
          64'h1111_1111);
    tick();
    idle();
    rq_wen = 2'b00;
    #1;
    check("solo_busy", 64'(arb_busy), 64'h1);
    tick();
    dmem_recv  = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    rq_ack     = 2'b01;
    #1;
    check("solo_recv", 64'(rq_recv), 64'h1);
    check("solo_data", 64'(rsp_rdata),
          64'hDEAD_BEEF);
    check("solo_dack", 64'(dmem_ack), 64'h1);
    tick();
    idle();
    #1;
    check("solo_idle", 64'(arb_busy), 64'h0);

    // Contention: round robin 0,1,0,1
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      rq_req    = 2'b11;
      dmem_gnt  = 1'b1;
      rq_ack    = 2'b11;
      dmem_recv = (i > 0);
      #1;
      check($sformatf("rr_gnt%0d", i),
            64'(rq_gnt),
            (i % 2 == 0) ? 64'h1 : 64'h2);
      if (i > 0)
        check($sformatf("rr_recv%0d", i),
              64'(rq_recv),
              (i % 2 == 1) ? 64'h1 : 64'h2);
      tick();
    end
    idle();
    dmem_recv = 1'b1;
    rq_ack    = 2'b11;
    #1;
    check("rr_last", 64'(rq_recv), 64'h2);
    tick();
    idle();
    #1;
    check("rr_idle", 64'(arb_busy), 64'h0);

    // Lock: requester 1 stalled, then both
    for (int i = 0; i < 3; i++) begin
      rq_req = 2'b10;
      #1;
      check($sformatf("lk_req%0d", i),
            64'(dmem_req), 64'h1);
      check($sformatf("lk_gnt%0d", i),
            64'(rq_gnt), 64'h0);
      tick();
    end
    rq_req = 2'b11;
    #1;
    check("lk_hold", 64'(dmem_addr), 64'h200);
    tick();
    dmem_gnt = 1'b1;
    #1;
    check("lk_gnt1", 64'(rq_gnt), 64'h2);
    tick();
    #1;
    check("lk_next0", 64'(rq_gnt), 64'h1);
    tick();
    idle();
    dmem_recv = 1'b1;
    rq_ack    = 2'b11;
    #1;
    check("lk_rsp1", 64'(rq_recv), 64'h2);
    tick();
    #1;
    check("lk_rsp0", 64'(rq_recv), 64'h1);
    tick();
    idle();

    // Full FIFO back-pressure
    rq_req   = 2'b01;
    dmem_gnt = 1'b1;
    tick();
    tick();
    #1;
    check("full_req", 64'(dmem_req), 64'h0);
    check("full_gnt", 64'(rq_gnt), 64'h0);
    check("full_busy", 64'(arb_busy), 64'h1);
    dmem_recv = 1'b1;
    rq_ack    = 2'b01;
    #1;
    check("full_pop_req", 64'(dmem_req), 64'h0);
    check("full_recv", 64'(rq_recv), 64'h1);
    tick();
    dmem_recv = 1'b0;
    #1;
    check("full_resume", 64'(dmem_req), 64'h1);
    check("full_rgnt", 64'(rq_gnt), 64'h1);
    tick();
    idle();
    dmem_recv = 1'b1;
    rq_ack    = 2'b01;
    tick();
    tick();
    idle();
    #1;
    check("full_drain", 64'(arb_busy), 64'h0);

    // Ordering and stalled acks
    rq_req   = 2'b01;
    dmem_gnt = 1'b1;
    tick();
    rq_req = 2'b10;
    tick();
    idle();
    dmem_recv  = 1'b1;
    dmem_error = 1'b1;
    #1;
    check("ord_recv0", 64'(rq_recv), 64'h1);
    check("ord_err1", 64'(rsp_error), 64'h1);
    check("ord_stall", 64'(dmem_ack), 64'h0);
    rq_ack = 2'b10;
    #1;
    check("ord_nohead", 64'(dmem_ack), 64'h0);
    tick();
    rq_ack = 2'b01;
    #1;
    check("ord_recv0b", 64'(rq_recv), 64'h1);
    check("ord_ack0", 64'(dmem_ack), 64'h1);
    tick();
    dmem_error = 1'b0;
    rq_ack     = 2'b10;
    #1;
    check("ord_recv1", 64'(rq_recv), 64'h2);
    check("ord_err0", 64'(rsp_error), 64'h0);
    tick();
    idle();

    // Spurious response with FIFO empty
    dmem_recv = 1'b1;
    #1;
    check("sp_ack", 64'(dmem_ack), 64'h1);
    check("sp_pulse", 64'(spurious), 64'h1);
    check("sp_recv", 64'(rq_recv), 64'h0);
    tick();
    idle();
    #1;
    check("sp_clear", 64'(spurious), 64'h0);

    // Reset with one transaction outstanding
    rq_req   = 2'b01;
    dmem_gnt = 1'b1;
    tick();
    idle();
    #1;
    check("rs_busy", 64'(arb_busy), 64'h1);
    g_reset = 1'b1;
    #1;
    check("rs_async", 64'(arb_busy), 64'h0);
    tick();
    g_reset   = 1'b0;
    dmem_recv = 1'b1;
    #1;
    check("rs_spur", 64'(spurious), 64'h1);
    check("rs_recv", 64'(rq_recv), 64'h0);
    check("rs_ack", 64'(dmem_ack), 64'h1);
    tick();
    idle();

    $display("%0d/%0d checks passed",
             n_pass, n_chk);
    $finish;
  end

endmodule
